nrzi_encode: RTL and testbench

USB full-speed transmitter and the transmit counterpart of the `nrzi_decode` receiver. It accepts a packet as a byte stream over a valid/ready handshake and emits a complete line packet on the differential pair: SYNC, then LSB-first NRZI data with bit stuffing, then EOP. It drives the USB transceiver pins together with an output enable, and runs on the same 4× bit-rate clock as the receiver.

---
 rtl/usb_pkg.sv | 24 ++
 rtl/usb_bit_timer.sv | 25 ++
 rtl/nrzi_encode.sv | 173 +++++++++++++++++
 tb/tb_nrzi_encode.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// rtl/usb_pkg.sv - shared USB line encodings, framing constants and transmit FSM states
package usb_pkg;

  // Line states as {dp, dn} at full speed
  typedef enum logic [1:0] {
    LINE_SE0 = 2'b00,
    LINE_K   = 2'b01,
    LINE_J   = 2'b10
  } line_t;

  localparam logic [7:0] SYNC_BYTE    = 8'h80;
  localparam logic [2:0] STUFF_LEN    = 3'd6;
  localparam logic [2:0] EOP_SE0_BITS = 3'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_ABORT,
    ST_EOP_SE0,
    ST_EOP_J
  } tx_state_t;

endpackage

// File: rtl/usb_bit_timer.sv
// rtl/usb_bit_timer.sv - 4-phase bit timer with start/end-of-bit strobes
module usb_bit_timer (
  input  logic clk4x,
  input  logic reset,
  input  logic clear,
  output logic bit_start,
  output logic bit_end
);

  logic [1:0] phase;

  always_ff @(posedge clk4x or negedge reset) begin
    if (!reset) begin
      phase <= 2'd0;
    end else if (clear) begin
      phase <= 2'd0;
    end else begin
      phase <= phase + 2'd1;
    end
  end

  assign bit_start = (phase == 2'd0);
  assign bit_end   = (phase == 2'd3);

endmodule

// File: rtl/nrzi_encode.sv
// rtl/nrzi_encode.sv - USB transmitter: SYNC, bit-stuffed NRZI data and EOP onto dp/dn
import usb_pkg::*;

module nrzi_encode #(
  parameter bit LOW_SPEED = 1'b0
) (
  input  logic       clk4x,
  input  logic       reset,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       dp,
  output logic       dn,
  output logic       oe,
  output logic       busy,
  output logic       underrun
);

  tx_state_t   state, state_n;
  logic [7:0]  shreg, shreg_n;
  logic [2:0]  bit_cnt, bit_cnt_n;
  logic [2:0]  ones, ones_n;
  logic        last_q, last_n;
  logic        level_j, level_j_n;
  logic [1:0]  line_q, line_n;
  logic        active_q, active_n;
  logic        bit_start, bit_end;
  logic        fetch, emit, hold;

  usb_bit_timer u_timer (
    .clk4x     (clk4x),
    .reset     (reset),
    .clear     (state == ST_IDLE),
    .bit_start (bit_start),
    .bit_end   (bit_end)
  );

  // A byte boundary is reached only once any pending stuff bit has gone out
  assign fetch = bit_end && (bit_cnt == 3'd0) &&
                 ((state == ST_SYNC) ||
                  ((state == ST_DATA) && !last_q && (ones != STUFF_LEN)));

  assign tx_ready = fetch && tx_valid;
  assign underrun = fetch && !tx_valid;

  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    bit_cnt_n = bit_cnt;
    ones_n    = ones;
    last_n    = last_q;
    level_j_n = level_j;
    line_n    = line_q;
    active_n  = active_q;
    emit      = 1'b0;
    hold      = 1'b0;

    case (state)
      ST_IDLE: begin
        line_n    = LINE_J;
        level_j_n = 1'b1;
        active_n  = 1'b0;
        bit_cnt_n = 3'd0;
        ones_n    = 3'd0;
        if (tx_valid) state_n = ST_SYNC;
      end
      ST_SYNC: begin
        if (bit_start) begin
          active_n  = 1'b1;
          emit      = 1'b1;
          hold      = SYNC_BYTE[bit_cnt];
          bit_cnt_n = bit_cnt + 3'd1;
          ones_n    = hold ? ones + 3'd1 : 3'd0;
        end
      end
      ST_DATA: begin
        if (bit_start) begin
          emit = 1'b1;
          if (ones == STUFF_LEN) begin
            hold   = 1'b0;
            ones_n = 3'd0;
          end else begin
            hold      = shreg[0];
            shreg_n   = {1'b0, shreg[7:1]};
            bit_cnt_n = bit_cnt + 3'd1;
            ones_n    = hold ? ones + 3'd1 : 3'd0;
          end
        end
        if (bit_end && (bit_cnt == 3'd0) && (ones != STUFF_LEN) && last_q) begin
          state_n = ST_EOP_SE0;
        end
      end
      ST_ABORT: begin
        if (bit_start) begin
          emit      = 1'b1;
          hold      = 1'b1;
          bit_cnt_n = bit_cnt + 3'd1;
        end
        if (bit_end && (bit_cnt == 3'd0)) state_n = ST_EOP_SE0;
      end
      ST_EOP_SE0: begin
        if (bit_start) begin
          line_n    = LINE_SE0;
          bit_cnt_n = bit_cnt + 3'd1;
        end
        if (bit_end && (bit_cnt == EOP_SE0_BITS)) begin
          state_n   = ST_EOP_J;
          bit_cnt_n = 3'd0;
        end
      end
      ST_EOP_J: begin
        // The J bit-time closes on the following phase-0 edge so oe spans all of it
        if (bit_start) begin
          if (bit_cnt == 3'd0) begin
            line_n    = LINE_J;
            level_j_n = 1'b1;
            bit_cnt_n = 3'd1;
          end else begin
            state_n   = ST_IDLE;
            active_n  = 1'b0;
            bit_cnt_n = 3'd0;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase

    if (fetch) begin
      if (tx_valid) begin
        shreg_n = tx_data;
        last_n  = tx_last;
        state_n = ST_DATA;
      end else begin
        state_n = ST_ABORT;
        ones_n  = 3'd0;
      end
    end

    if (emit) begin
      level_j_n = hold ? level_j : ~level_j;
      line_n    = level_j_n ? LINE_J : LINE_K;
    end
  end

  always_ff @(posedge clk4x or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      shreg    <= 8'h00;
      bit_cnt  <= 3'd0;
      ones     <= 3'd0;
      last_q   <= 1'b0;
      level_j  <= 1'b1;
      line_q   <= LINE_J;
      active_q <= 1'b0;
    end else begin
      state    <= state_n;
      shreg    <= shreg_n;
      bit_cnt  <= bit_cnt_n;
      ones     <= ones_n;
      last_q   <= last_n;
      level_j  <= level_j_n;
      line_q   <= line_n;
      active_q <= active_n;
    end
  end

  assign dp   = LOW_SPEED ? line_q[0] : line_q[1];
  assign dn   = LOW_SPEED ? line_q[1] : line_q[0];
  assign oe   = active_q;
  assign busy = active_q;

endmodule

// File: tb/tb_nrzi_encode.sv
// tb/tb_nrzi_encode.sv - directed self-checking bench for nrzi_encode
module tb_nrzi_encode;

  localparam logic [1:0] LJ  = 2'b10;
  localparam logic [1:0] LK  = 2'b01;
  localparam logic [1:0] LS0 = 2'b00;

  logic       clk4x = 1'b0;
  logic       reset = 1'b0;
  logic       tx_valid = 1'b0;
  logic       tx_last = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, dp, dn, oe, busy, underrun;
  logic       ls_ready, ls_dp, ls_dn, ls_oe, ls_busy, ls_underrun;

  int n_checks = 0;
  int n_fail = 0;

  logic [7:0] pkt_bytes [4];
  int         pkt_len;
  logic       pkt_last;
  logic [1:0] syms [$];
  logic [1:0] ls_syms [$];
  int         ready_cyc [$];
  int         underrun_cnt, oe_cycles, busy_gap;
  bit         timed_out;

  logic [1:0] sync_exp [8];

  always #5 clk4x = ~clk4x;

  nrzi_encode #(.LOW_SPEED(1'b0)) dut (
    .clk4x(clk4x), .reset(reset), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_last(tx_last), .tx_ready(tx_ready), .dp(dp), .dn(dn), .oe(oe),
    .busy(busy), .underrun(underrun)
  );

  nrzi_encode #(.LOW_SPEED(1'b1)) dut_ls (
    .clk4x(clk4x), .reset(reset), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_last(tx_last), .tx_ready(ls_ready), .dp(ls_dp), .dn(ls_dn), .oe(ls_oe),
    .busy(ls_busy), .underrun(ls_underrun)
  );

  // Feeds pkt_bytes and records one line symbol per bit-time while oe is high
  task automatic send_packet();
    int  idx, cyc;
    bit  adv;
    syms.delete(); ls_syms.delete(); ready_cyc.delete();
    underrun_cnt = 0; oe_cycles = 0; busy_gap = 0; timed_out = 0;
    idx = 0; adv = 0;
    @(negedge clk4x);
    tx_data = pkt_bytes[0]; tx_last = pkt_last && (pkt_len == 1); tx_valid = 1'b1;
    cyc = 0;
    do begin @(negedge clk4x); cyc++; end while (!oe && cyc < 20);
    if (!oe) begin timed_out = 1; tx_valid = 1'b0; return; end
    cyc = 0;
    while (oe && cyc < 3000) begin
      if (adv) begin
        adv = 0; idx++;
        if (idx < pkt_len) begin
          tx_data = pkt_bytes[idx]; tx_last = pkt_last && (idx == pkt_len - 1);
        end else begin
          tx_valid = 1'b0;
        end
      end
      if (cyc % 4 == 1) begin
        syms.push_back({dp, dn});
        ls_syms.push_back({ls_dp, ls_dn});
      end
      if (tx_ready) begin ready_cyc.push_back(cyc); adv = 1; end
      if (underrun) underrun_cnt++;
      if (busy !== oe || ls_oe !== oe) busy_gap++;
      @(negedge clk4x); cyc++;
    end
    oe_cycles = cyc;
    if (oe) timed_out = 1;
    tx_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk4x);
    n_checks++;
    if ({dp, dn, oe, tx_ready, busy, underrun} !== 6'b100000) begin
      n_fail++; $display("FAIL reset_outputs: got %b want 100000", {dp, dn, oe, tx_ready, busy, underrun});
    end
    n_checks++;
    if ({ls_dp, ls_dn, ls_oe} !== 3'b010) begin
      n_fail++; $display("FAIL reset_ls_outputs: got %b want 010", {ls_dp, ls_dn, ls_oe});
    end
    reset = 1'b1;
    repeat (3) @(negedge clk4x);
    n_checks++;
    if ({dp, dn, oe, busy} !== 4'b1000) begin
      n_fail++; $display("FAIL idle_after_reset: got %b want 1000", {dp, dn, oe, busy});
    end
  endtask

  task automatic test_single_zero();
    logic [1:0] exp [19];
    exp = '{LK, LJ, LK, LJ, LK, LJ, LK, LK, LJ, LK, LJ, LK, LJ, LK, LJ, LK, LS0, LS0, LJ};
    pkt_bytes[0] = 8'h00; pkt_len = 1; pkt_last = 1'b1;
    send_packet();
    n_checks++;
    if (timed_out !== 1'b0) begin n_fail++; $display("FAIL zero_timeout: got %b want 0", timed_out); end
    n_checks++;
    if (oe_cycles != 76) begin n_fail++; $display("FAIL zero_oe_len: got %0d want 76", oe_cycles); end
    n_checks++;
    if (syms.size() != 19) begin n_fail++; $display("FAIL zero_sym_count: got %0d want 19", syms.size()); end
    for (int i = 0; i < 19 && i < syms.size(); i++) begin
      n_checks++;
      if (syms[i] !== exp[i]) begin n_fail++; $display("FAIL zero_sym[%0d]: got %b want %b", i, syms[i], exp[i]); end
    end
    n_checks++;
    if (ready_cyc.size() != 1) begin n_fail++; $display("FAIL zero_ready_count: got %0d want 1", ready_cyc.size()); end
    if (ready_cyc.size() >= 1) begin
      n_checks++;
      if (ready_cyc[0] + 1 != 31) begin n_fail++; $display("FAIL zero_ready_time: got %0d want 31", ready_cyc[0] + 1); end
    end
    n_checks++;
    if (busy_gap != 0) begin n_fail++; $display("FAIL zero_busy_track: got %0d want 0", busy_gap); end
  endtask

  task automatic test_single_ff();
    logic [1:0] exp [20];
    exp = '{LK, LJ, LK, LJ, LK, LJ, LK, LK, LK, LK, LK, LK, LK, LJ, LJ, LJ, LJ, LS0, LS0, LJ};
    pkt_bytes[0] = 8'hFF; pkt_len = 1; pkt_last = 1'b1;
    send_packet();
    n_checks++;
    if (oe_cycles != 80) begin n_fail++; $display("FAIL ff_oe_len: got %0d want 80", oe_cycles); end
    n_checks++;
    if (syms.size() != 20) begin n_fail++; $display("FAIL ff_sym_count: got %0d want 20", syms.size()); end
    for (int i = 0; i < 20 && i < syms.size(); i++) begin
      n_checks++;
      if (syms[i] !== exp[i]) begin n_fail++; $display("FAIL ff_sym[%0d]: got %b want %b", i, syms[i], exp[i]); end
    end
  endtask

  task automatic test_multi_byte();
    logic [1:0]  prev;
    logic [23:0] bits;
    int          ones, nb;
    pkt_bytes[0] = 8'hC3; pkt_bytes[1] = 8'h5A; pkt_bytes[2] = 8'h3C;
    pkt_len = 3; pkt_last = 1'b1;
    send_packet();
    n_checks++;
    if (oe_cycles != 140) begin n_fail++; $display("FAIL multi_oe_len: got %0d want 140", oe_cycles); end
    n_checks++;
    if (ready_cyc.size() != 3) begin n_fail++; $display("FAIL multi_ready_count: got %0d want 3", ready_cyc.size()); end
    for (int i = 1; i < 3 && i < ready_cyc.size(); i++) begin
      n_checks++;
      if (ready_cyc[i] - ready_cyc[i-1] != 32) begin
        n_fail++; $display("FAIL multi_ready_gap[%0d]: got %0d want 32", i, ready_cyc[i] - ready_cyc[i-1]);
      end
    end
    n_checks++;
    if (underrun_cnt != 0) begin n_fail++; $display("FAIL multi_underrun: got %0d want 0", underrun_cnt); end
    bits = 24'h0; nb = 0; ones = 1;
    prev = (syms.size() > 7) ? syms[7] : LK;
    for (int i = 8; i < syms.size() && nb < 24; i++) begin
      logic b;
      b = (syms[i] == prev);
      prev = syms[i];
      if (ones == 6) begin ones = 0; continue; end
      bits[nb] = b; nb++;
      ones = b ? ones + 1 : 0;
    end
    n_checks++;
    if (bits[7:0] !== 8'hC3) begin n_fail++; $display("FAIL multi_byte0: got %h want c3", bits[7:0]); end
    n_checks++;
    if (bits[15:8] !== 8'h5A) begin n_fail++; $display("FAIL multi_byte1: got %h want 5a", bits[15:8]); end
    n_checks++;
    if (bits[23:16] !== 8'h3C) begin n_fail++; $display("FAIL multi_byte2: got %h want 3c", bits[23:16]); end
    n_checks++;
    if (syms.size() != 35) begin
      n_fail++; $display("FAIL multi_sym_count: got %0d want 35", syms.size());
    end else begin
      n_checks++;
      if ({syms[32], syms[33], syms[34]} !== {LS0, LS0, LJ}) begin
        n_fail++; $display("FAIL multi_eop: got %b want %b", {syms[32], syms[33], syms[34]}, {LS0, LS0, LJ});
      end
    end
  endtask

  task automatic test_underrun();
    logic [1:0] exp [27];
    exp = '{LK, LJ, LK, LJ, LK, LJ, LK, LK, LK, LJ, LJ, LK, LJ, LJ, LK, LK,
            LK, LK, LK, LK, LK, LK, LK, LK, LS0, LS0, LJ};
    pkt_bytes[0] = 8'hA5; pkt_len = 1; pkt_last = 1'b0;
    send_packet();
    n_checks++;
    if (underrun_cnt != 1) begin n_fail++; $display("FAIL underrun_count: got %0d want 1", underrun_cnt); end
    n_checks++;
    if (ready_cyc.size() != 1) begin n_fail++; $display("FAIL underrun_ready_count: got %0d want 1", ready_cyc.size()); end
    n_checks++;
    if (oe_cycles != 108) begin n_fail++; $display("FAIL underrun_oe_len: got %0d want 108", oe_cycles); end
    for (int i = 8; i < 27 && i < syms.size(); i++) begin
      n_checks++;
      if (syms[i] !== exp[i]) begin n_fail++; $display("FAIL underrun_sym[%0d]: got %b want %b", i, syms[i], exp[i]); end
    end
    n_checks++;
    if (oe !== 1'b0) begin n_fail++; $display("FAIL underrun_oe_end: got %b want 0", oe); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk4x);
    tx_data = 8'h00; tx_last = 1'b1; tx_valid = 1'b1;
    repeat (45) @(negedge clk4x);
    tx_valid = 1'b0;
    n_checks++;
    if (oe !== 1'b1) begin n_fail++; $display("FAIL midreset_pre_oe: got %b want 1", oe); end
    reset = 1'b0;
    #1;
    n_checks++;
    if ({dp, dn, oe, busy} !== 4'b1000) begin
      n_fail++; $display("FAIL midreset_force: got %b want 1000", {dp, dn, oe, busy});
    end
    @(negedge clk4x);
    reset = 1'b1;
    repeat (2) @(negedge clk4x);
    pkt_bytes[0] = 8'h00; pkt_len = 1; pkt_last = 1'b1;
    send_packet();
    n_checks++;
    if (oe_cycles != 76) begin n_fail++; $display("FAIL midreset_oe_len: got %0d want 76", oe_cycles); end
    for (int i = 0; i < 8 && i < syms.size(); i++) begin
      n_checks++;
      if (syms[i] !== sync_exp[i]) begin n_fail++; $display("FAIL midreset_sync[%0d]: got %b want %b", i, syms[i], sync_exp[i]); end
    end
  endtask

  task automatic test_low_speed();
    logic [1:0] exp [19];
    logic [1:0] e;
    exp = '{LK, LJ, LK, LJ, LK, LJ, LK, LK, LJ, LK, LJ, LK, LJ, LK, LJ, LK, LS0, LS0, LJ};
    n_checks++;
    if ({ls_dp, ls_dn} !== 2'b01) begin n_fail++; $display("FAIL ls_idle: got %b want 01", {ls_dp, ls_dn}); end
    pkt_bytes[0] = 8'h00; pkt_len = 1; pkt_last = 1'b1;
    send_packet();
    n_checks++;
    if (ls_syms.size() != 19) begin n_fail++; $display("FAIL ls_sym_count: got %0d want 19", ls_syms.size()); end
    for (int i = 0; i < 19 && i < ls_syms.size(); i++) begin
      e = exp[i];
      n_checks++;
      if (ls_syms[i] !== {e[0], e[1]}) begin
        n_fail++; $display("FAIL ls_sym[%0d]: got %b want %b", i, ls_syms[i], {e[0], e[1]});
      end
    end
    @(negedge clk4x);
    n_checks++;
    if ({ls_dp, ls_dn, ls_busy, ls_underrun, ls_ready} !== 5'b01000) begin
      n_fail++; $display("FAIL ls_idle_after: got %b want 01000", {ls_dp, ls_dn, ls_busy, ls_underrun, ls_ready});
    end
  endtask

  initial begin
    sync_exp = '{LK, LJ, LK, LJ, LK, LJ, LK, LK};
    test_reset();
    test_single_zero();
    test_single_ff();
    test_multi_byte();
    test_underrun();
    test_reset_mid();
    test_low_speed();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
